// File: rtl/saber_mac_lanes_if.sv
// Stream bundle for saber_mac_lanes: coefficient/secret beats in, accumulator words out.
interface saber_mac_lanes_if #(
  parameter int LANES = 4,
  parameter int QW    = 13,
  parameter int SW    = 4,
  parameter int OW    = 16
);
  logic                  in_valid;
  logic                  in_ready;
  logic [QW-1:0]         a;
  logic [LANES*SW-1:0]   s;
  logic [LANES*QW-1:0]   r;
  logic                  neg;
  logic                  out_valid;
  logic                  out_ready;
  logic [LANES*OW-1:0]   result;
  logic                  err;

  modport master (
    output in_valid, a, s, r, neg, out_ready,
    input  in_ready, out_valid, result, err
  );

  modport slave (
    input  in_valid, a, s, r, neg, out_ready,
    output in_ready, out_valid, result, err
  );
endinterface

// File: rtl/saber_mac_lanes.sv
// Two-stage multi-lane multiply-accumulate for the Saber schoolbook multiplier:
// result[i] = r[i] +/- a*|s[i]| mod 2^QW, with a single shared pipeline enable.
module saber_mac_lanes #(
  parameter int LANES   = 4,
  parameter int QW      = 13,
  parameter int SW      = 4,
  parameter int MAX_MAG = 4,
  parameter int OW      = 16
) (
  input logic              clk,
  input logic              rst,
  saber_mac_lanes_if.slave mac
);

  localparam int MW = SW - 1;

  logic                r_v1;
  logic                r_v2;
  logic                r_err;
  logic [LANES*OW-1:0] r_result;
  logic [QW-1:0]       r_acc  [LANES];
  logic                r_sgn  [LANES];
  logic [MW-1:0]       r_mag  [LANES];
  logic [QW-1:0]       r_mult [1:MAX_MAG];

  logic                w_en;
  logic                w_accept;
  logic                w_illegal;
  logic [QW-1:0]       w_mult [1:MAX_MAG];
  logic [QW-1:0]       w_prod [LANES];
  logic [QW-1:0]       w_lane [LANES];
  logic [LANES*OW-1:0] w_result;

  assign w_en         = !r_v2 || mac.out_ready;
  assign w_accept     = mac.in_valid && w_en;
  assign mac.in_ready = w_en;

  // a*k built as a doubling/adding chain so no multiplier is inferred
  for (genvar k = 1; k <= MAX_MAG; k++) begin : g_mult
    if (k == 1) begin : g_one
      assign w_mult[k] = mac.a;
    end else if ((k % 2) == 0) begin : g_even
      assign w_mult[k] = {w_mult[k/2][QW-2:0], 1'b0};
    end else begin : g_odd
      assign w_mult[k] = w_mult[k-1] + mac.a;
    end
  end

  always_comb begin
    w_illegal = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      if (int'(mac.s[i*SW +: MW]) > MAX_MAG) w_illegal = 1'b1;
    end
  end

  // Out-of-range and zero magnitudes both fall through to a zero product
  always_comb begin
    w_result = '0;
    for (int i = 0; i < LANES; i++) begin
      w_prod[i] = '0;
      for (int k = 1; k <= MAX_MAG; k++) begin
        if (int'(r_mag[i]) == k) w_prod[i] = r_mult[k];
      end
      w_lane[i] = r_sgn[i] ? (r_acc[i] - w_prod[i]) : (r_acc[i] + w_prod[i]);
      w_result[i*OW +: OW] = OW'(w_lane[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1     <= 1'b0;
      r_v2     <= 1'b0;
      r_err    <= 1'b0;
      r_result <= '0;
      for (int i = 0; i < LANES; i++) begin
        r_acc[i] <= '0;
        r_sgn[i] <= 1'b0;
        r_mag[i] <= '0;
      end
      for (int k = 1; k <= MAX_MAG; k++) begin
        r_mult[k] <= '0;
      end
    end else begin
      if (w_en) begin
        r_v1 <= mac.in_valid;
        if (mac.in_valid) begin
          for (int i = 0; i < LANES; i++) begin
            r_acc[i] <= mac.r[i*QW +: QW];
            r_sgn[i] <= mac.s[i*SW + SW - 1] ^ mac.neg;
            r_mag[i] <= mac.s[i*SW +: MW];
          end
          for (int k = 1; k <= MAX_MAG; k++) begin
            r_mult[k] <= w_mult[k];
          end
        end
        r_v2 <= r_v1;
        if (r_v1) r_result <= w_result;
      end
      if (w_accept && w_illegal) r_err <= 1'b1;
    end
  end

  assign mac.out_valid = r_v2;
  assign mac.result    = r_result;
  assign mac.err       = r_err;

endmodule

// File: tb/tb_saber_mac_lanes.sv
// Scoreboard bench for saber_mac_lanes: random and directed beats against an arithmetic model.
module tb_saber_mac_lanes;
  localparam int LANES   = 4;
  localparam int QW      = 13;
  localparam int SW      = 4;
  localparam int MAX_MAG = 4;
  localparam int OW      = 16;

  logic clk;
  logic rst;
  int   n_vec  = 0;
  int   n_miss = 0;
  logic err_exp = 1'b0;
  bit   soak_on = 1'b0;
  logic [LANES*OW-1:0] exp_q[$];

  saber_mac_lanes_if #(.LANES(LANES), .QW(QW), .SW(SW), .OW(OW)) mac ();

  saber_mac_lanes #(.LANES(LANES), .QW(QW), .SW(SW), .MAX_MAG(MAX_MAG), .OW(OW)) dut (
    .clk (clk),
    .rst (rst),
    .mac (mac)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  // Reference: plain integer arithmetic mod 2^QW, lane by lane
  function automatic logic [LANES*OW-1:0] model(input logic [QW-1:0] av, input logic [LANES*SW-1:0] sv,
                                                input logic [LANES*QW-1:0] rv, input logic nv);
    logic [LANES*OW-1:0] o;
    int m, mag, acc, p, res;
    bit sub;
    o = '0;
    m = 1 << QW;
    for (int i = 0; i < LANES; i++) begin
      mag = int'(sv[i*SW +: SW-1]);
      sub = sv[i*SW + SW - 1] ^ nv;
      acc = int'(rv[i*QW +: QW]);
      p   = (mag >= 1 && mag <= MAX_MAG) ? (int'(av) * mag) % m : 0;
      res = sub ? (acc - p + m) % m : (acc + p) % m;
      o[i*OW +: OW] = OW'(res);
    end
    return o;
  endfunction

  function automatic bit illegal(input logic [LANES*SW-1:0] sv);
    bit b;
    b = 1'b0;
    for (int i = 0; i < LANES; i++) if (int'(sv[i*SW +: SW-1]) > MAX_MAG) b = 1'b1;
    return b;
  endfunction

  function automatic logic [LANES*SW-1:0] rand_s(input bit allow_bad);
    logic [LANES*SW-1:0] o;
    int mag;
    o = '0;
    for (int i = 0; i < LANES; i++) begin
      if (allow_bad && $urandom_range(0, 9) == 0) mag = $urandom_range(MAX_MAG + 1, (1 << (SW-1)) - 1);
      else mag = $urandom_range(0, MAX_MAG);
      o[i*SW + SW - 1] = 1'($urandom);
      o[i*SW +: SW-1]  = (SW-1)'(mag);
    end
    return o;
  endfunction

  function automatic logic [LANES*QW-1:0] rand_r();
    logic [LANES*QW-1:0] o;
    o = '0;
    for (int i = 0; i < LANES; i++) o[i*QW +: QW] = QW'($urandom);
    return o;
  endfunction

  // Presents a beat at a negedge and returns right after the edge that accepts it
  task automatic send(input logic [QW-1:0] av, input logic [LANES*SW-1:0] sv,
                      input logic [LANES*QW-1:0] rv, input logic nv);
    int waitc;
    waitc = 0;
    @(negedge clk);
    mac.in_valid = 1'b1;
    mac.a = av;
    mac.s = sv;
    mac.r = rv;
    mac.neg = nv;
    #1;
    while (!mac.in_ready && waitc < 200) begin
      waitc++;
      @(negedge clk);
      #1;
    end
    if (!mac.in_ready) begin
      n_vec++;
      n_miss++;
      $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles", waitc);
      mac.in_valid = 1'b0;
      return;
    end
    exp_q.push_back(model(av, sv, rv, nv));
    @(posedge clk);
    if (illegal(sv)) err_exp = 1'b1;
  endtask

  task automatic send_chk(input logic [QW-1:0] av, input logic [LANES*SW-1:0] sv,
                          input logic [LANES*QW-1:0] rv, input logic nv,
                          input int lane, input logic [OW-1:0] want);
    send(av, sv, rv, nv);
    #1;
    chk("lat_not_early", 64'(mac.out_valid), 64'd0);
    @(negedge clk);
    mac.in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("lat_two_cycles", 64'(mac.out_valid), 64'd1);
    chk($sformatf("lane%0d_value", lane), 64'(mac.result[lane*OW +: OW]), 64'(want));
  endtask

  task automatic drain();
    int c;
    c = 0;
    while ((mac.out_valid || exp_q.size() != 0) && c < 50) begin
      @(negedge clk);
      #3;
      c++;
    end
    chk("drain_queue_empty", 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: pops one expectation per output handshake
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst && mac.out_valid && mac.out_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL extra_output: got %0h expected no output", mac.result);
        end else begin
          chk("result", 64'(mac.result), 64'(exp_q.pop_front()));
          chk("err_track", 64'(mac.err), 64'(err_exp));
        end
      end
    end
  end

  initial begin
    while (!soak_on) @(negedge clk);
    while (soak_on) begin
      @(negedge clk);
      mac.out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss + 1);
    $fatal(1);
  end

  initial begin
    logic [QW-1:0]       av;
    logic [LANES*SW-1:0] sv;
    logic [LANES*QW-1:0] rv;
    logic [LANES*OW-1:0] res_a;

    rst = 1'b1;
    mac.in_valid = 1'b0;
    mac.a = '0;
    mac.s = '0;
    mac.r = '0;
    mac.neg = 1'b0;
    mac.out_ready = 1'b0;
    #12;
    chk("rst_out_valid", 64'(mac.out_valid), 64'd0);
    chk("rst_result", 64'(mac.result), 64'd0);
    chk("rst_err", 64'(mac.err), 64'd0);
    chk("rst_in_ready", 64'(mac.in_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    mac.out_ready = 1'b1;

    // Directed arithmetic cases, lane 0 carries the vector, other lanes random
    sv = rand_s(0); sv[3:0] = 4'b0011; rv = rand_r(); rv[12:0] = 13'd5;
    send_chk(13'h1FFF, sv, rv, 1'b0, 0, 16'h0002);
    sv = rand_s(0); sv[3:0] = 4'b1001; rv = rand_r(); rv[12:0] = 13'd0;
    send_chk(13'd1, sv, rv, 1'b0, 0, 16'h1FFF);
    send_chk(13'd1, sv, rv, 1'b1, 0, 16'h0001);
    sv = rand_s(0); sv[3:0] = 4'b0010; rv = rand_r(); rv[12:0] = 13'd100;
    send_chk(13'd10, sv, rv, 1'b1, 0, 16'd80);
    sv[3:0] = 4'b1000;
    send_chk(13'd10, sv, rv, 1'b0, 0, 16'd100);
    sv[3:0] = 4'b0100;
    send_chk(13'd10, sv, rv, 1'b0, 0, 16'd140);
    chk("err_clear_legal", 64'(mac.err), 64'd0);

    // Illegal magnitude on lane 2 only
    sv = rand_s(0); sv[11:8] = 4'b0101; rv = rand_r(); rv[2*QW +: QW] = 13'd77;
    send(13'($urandom), sv, rv, 1'($urandom));
    #1;
    chk("err_at_accept", 64'(mac.err), 64'd1);
    @(negedge clk);
    mac.in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("illegal_lane_passthru", 64'(mac.result[2*OW +: OW]), 64'd77);
    for (int i = 0; i < 10; i++) send(13'($urandom), rand_s(0), rand_r(), 1'($urandom));
    @(negedge clk);
    mac.in_valid = 1'b0;
    drain();
    chk("err_sticky", 64'(mac.err), 64'd1);

    // Backpressure: two beats fill the pipe, the third must wait
    @(negedge clk);
    mac.out_ready = 1'b0;
    av = 13'($urandom); sv = rand_s(0); rv = rand_r();
    res_a = model(av, sv, rv, 1'b0);
    send(av, sv, rv, 1'b0);
    send(13'($urandom), rand_s(0), rand_r(), 1'b1);
    av = 13'($urandom); sv = rand_s(0); rv = rand_r();
    @(negedge clk);
    mac.a = av;
    mac.s = sv;
    mac.r = rv;
    mac.neg = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_in_ready_low", 64'(mac.in_ready), 64'd0);
      chk("bp_result_stable", 64'(mac.result), 64'(res_a));
      @(negedge clk);
    end
    mac.in_valid = 1'b0;
    mac.out_ready = 1'b1;
    send(av, sv, rv, 1'b0);
    @(negedge clk);
    mac.in_valid = 1'b0;
    drain();

    // Random valid/ready soak
    soak_on = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        mac.in_valid = 1'b0;
      end
      send(13'($urandom), rand_s(1), rand_r(), 1'($urandom));
    end
    @(negedge clk);
    mac.in_valid = 1'b0;
    soak_on = 1'b0;
    @(negedge clk);
    @(negedge clk);
    mac.out_ready = 1'b1;
    drain();

    // Asynchronous reset with both stages full
    @(negedge clk);
    mac.out_ready = 1'b0;
    send(13'($urandom), rand_s(0), rand_r(), 1'b0);
    send(13'($urandom), rand_s(0), rand_r(), 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_out_valid", 64'(mac.out_valid), 64'd0);
    chk("async_rst_result", 64'(mac.result), 64'd0);
    chk("async_rst_err", 64'(mac.err), 64'd0);
    mac.in_valid = 1'b0;
    exp_q.delete();
    err_exp = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    mac.out_ready = 1'b1;
    sv = rand_s(0); sv[3:0] = 4'b0010; rv = rand_r(); rv[12:0] = 13'd100;
    send_chk(13'd10, sv, rv, 1'b0, 0, 16'd120);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
